// File: rtl/full_bit_adder.sv
// ---------------------------------------------------------------------------
// full_bit_adder_cell
//   One-bit full adder used as the ripple-chain building block.
//   a_i, b_i : operand bits
//   ci_i     : carry in
//   s_o      : sum bit       (a ^ b ^ ci)
//   co_o     : carry out     (majority of a, b, ci)
// ---------------------------------------------------------------------------
module full_bit_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// ---------------------------------------------------------------------------
// full_bit_adder
//   Registered WIDTH-bit ripple-carry adder: {c_out, SUM} <= ina + inb + c_in
//   one clock after the operands are presented. Overflow wraps modulo
//   2^WIDTH with the wrapped-out bit on c_out.
//   clk   : clock, rising edge active
//   rst   : synchronous reset, active high; clears SUM and c_out
//   ina   : operand A, unsigned
//   inb   : operand B, unsigned
//   c_in  : carry into bit 0
//   SUM   : registered sum
//   c_out : registered carry out of the MSB cell
// ---------------------------------------------------------------------------
module full_bit_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             c_in,
  output logic [WIDTH-1:0] SUM,
  output logic             c_out
);

  // carry[i] enters cell i; carry[WIDTH] leaves the top cell.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_bit_adder_cell u_cell (
      .a_i  (ina[i]),
      .b_i  (inb[i]),
      .ci_i (carry[i]),
      .s_o  (sum_d[i]),
      .co_o (carry[i+1])
    );
  end

  assign cout_d = carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign SUM   = sum_q;
  assign c_out = cout_q;

endmodule

// File: tb/tb_full_bit_adder.sv
// ---------------------------------------------------------------------------
// tb_full_bit_adder
//   Directed and swept stimulus for full_bit_adder (WIDTH = 8). A reference
//   model computes the registered (WIDTH+1)-bit add with plain arithmetic;
//   a compare process checks the DUT against it every falling edge, and
//   directed steps check both DUT and model against hand-computed values.
// ---------------------------------------------------------------------------
module tb_full_bit_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] ina;
  logic [W-1:0] inb;
  logic         c_in;
  logic [W-1:0] SUM;
  logic         c_out;

  int n_checks = 0;
  int n_pass   = 0;

  full_bit_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .ina   (ina),
    .inb   (inb),
    .c_in  (c_in),
    .SUM   (SUM),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: result of the inputs seen at the last rising edge.
  logic [W:0] exp_q;
  logic       exp_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) exp_q <= '0;
    else     exp_q <= (W+1)'(ina) + (W+1)'(inb) + (W+1)'(c_in);
    exp_valid <= 1'b1;
  end

  // Continuous comparison, sampled away from the active edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      n_checks++;
      if ({c_out, SUM} === exp_q) n_pass++;
      else $display("FAIL model_cmp t=%0t got c_out=%0b SUM=%0d expected c_out=%0b SUM=%0d",
                    $time, c_out, SUM, exp_q[W], exp_q[W-1:0]);
    end
  end

  task automatic check_lit(input string name, input logic [W-1:0] es, input logic ec);
    n_checks++;
    if (SUM === es && c_out === ec) n_pass++;
    else $display("FAIL %s got c_out=%0b SUM=%0d expected c_out=%0b SUM=%0d",
                  name, c_out, SUM, ec, es);
    n_checks++;
    if (exp_q === {ec, es}) n_pass++;
    else $display("FAIL %s_model got %0d expected %0d", name, exp_q, {ec, es});
  endtask

  // Present operands, let one edge capture them, then check literals.
  task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input string name,
                      input logic [W-1:0] es, input logic ec);
    rst = r; ina = a; inb = b; c_in = c;
    @(posedge clk);
    #2;
    check_lit(name, es, ec);
  endtask

  initial begin
    rst = 1'b1; ina = '0; inb = '0; c_in = 1'b0;
    @(posedge clk);
    #2;
    check_lit("reset", 8'd0, 1'b0);

    step(1'b0, 8'd0,   8'd0,   1'b0, "zero_add",   8'd0,   1'b0);
    step(1'b0, 8'd10,  8'd5,   1'b0, "add_10_5",   8'd15,  1'b0);
    step(1'b0, 8'd10,  8'd2,   1'b0, "add_10_2",   8'd12,  1'b0);
    step(1'b0, 8'd0,   8'd0,   1'b1, "cin_only",   8'd1,   1'b0);
    step(1'b0, 8'd15,  8'd15,  1'b0, "add_15_15",  8'd30,  1'b0);
    step(1'b0, 8'd255, 8'd0,   1'b1, "ripple_all", 8'd0,   1'b1);
    step(1'b0, 8'd255, 8'd255, 1'b1, "max_max_1",  8'd255, 1'b1);
    step(1'b0, 8'd128, 8'd128, 1'b0, "msb_ovf",    8'd0,   1'b1);

    // Inputs change mid-cycle; only the value at the edge is captured,
    // and the previous result must still be held before that edge.
    ina = 8'd10; inb = 8'd5; c_in = 1'b0;
    #3;
    check_lit("hold_prev", 8'd0, 1'b1);
    ina = 8'd3; inb = 8'd3;
    @(posedge clk);
    #2;
    check_lit("last_wins", 8'd6, 1'b0);

    // Reset mid-stream discards the pending result.
    step(1'b0, 8'd100, 8'd100, 1'b0, "add_100_100", 8'd200, 1'b0);
    step(1'b1, 8'd100, 8'd100, 1'b0, "mid_reset",   8'd0,   1'b0);
    step(1'b0, 8'd1,   8'd1,   1'b0, "post_reset",  8'd2,   1'b0);

    // Sweep across the operand space, both carry-in values; checked
    // by the compare process against the model.
    for (int a = 0; a < 256; a += 3) begin
      for (int b = 0; b < 256; b += 7) begin
        for (int c = 0; c < 2; c++) begin
          ina = W'(a); inb = W'(b); c_in = c[0];
          @(posedge clk);
          #2;
        end
      end
    end
    for (int k = 0; k < 2000; k++) begin
      ina = W'($urandom_range(255)); inb = W'($urandom_range(255));
      c_in = 1'($urandom_range(1));
      @(posedge clk);
      #2;
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running expected finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/full_bit_adder.md
Name: full_bit_adder

Overview:
- Registered N-bit ripple-carry adder, default 8 bits, built from a chain of 1-bit full-adder cells.
- Computes ina + inb + c_in combinationally through the carry chain.
- Captures SUM and c_out in output registers on the rising clock edge.
- Generic arithmetic leaf block for datapaths that need a registered add with carry-in and carry-out.

Parameters:
- WIDTH, 8, operand and SUM width in bits; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- ina  input  WIDTH  operand A, unsigned.
- inb  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- SUM  output  WIDTH  registered sum bits [WIDTH-1:0].
- c_out  output  1  registered carry out of bit WIDTH-1.

Interface decision (fixed): one clock; reset is synchronous and active-high. Ports are named clk and rst.

Behaviour:
- Datapath structure:
  - Combinational ripple chain of WIDTH 1-bit full-adder cells, as a separate submodule instantiated per bit (generate loop).
  - Each cell computes s = a ^ b ^ ci and co = (a & b) | (a & ci) | (b & ci).
  - Bit 0 carry-in is c_in. Cell i carry-in is the carry-out of cell i-1.
  - Final carry-out feeds c_out.
- Arithmetic: {c_out, SUM} = ina + inb + c_in, evaluated as an unsigned (WIDTH+1)-bit result.
  - No saturation.
  - Overflow wraps modulo 2^WIDTH, with the wrapped-out bit appearing on c_out.
- Timing:
  - On each rising clk edge with rst=0, SUM and c_out load the combinational result of the ina, inb and c_in values present just before the edge.
  - Latency is 1 cycle; throughput is one addition per cycle.
  - Outputs hold between edges regardless of input changes.
- Reset:
  - rst=1 at a rising edge forces SUM=0 and c_out=0.
  - Reset has priority over the add; inputs are ignored during that cycle.
  - Reset asserted mid-stream discards the pending result. The first valid result appears one edge after rst deasserts, computed from the inputs present at that edge.
- Power-up: outputs are undefined until the first reset edge or the first clocked load. Simulation may show X before then.
- No handshake; the block always accepts inputs. No internal state besides the WIDTH+1 output flops.
- X on any input propagates to the corresponding output bits. No X-masking.

Boundary cases:
- All-zero inputs with c_in=0 give 0 with c_out=0.
- Max+max+1 (255+255+1) gives SUM=255, c_out=1.
- c_in alone propagating through an all-ones operand produces a full-length ripple. The worst-case combinational path is c_in to c_out through WIDTH cells and must meet clk period.

Test Plan:
- Reset, then zero add: rst=1 for one edge -> SUM=0, c_out=0. Then rst=0, ina=0, inb=0, c_in=0 -> after next edge SUM=00000000, c_out=0.
- Simple adds, one per cycle, checked one edge later:
  - ina=10, inb=5, c_in=0 -> SUM=15 (00001111), c_out=0.
  - Next cycle ina=10, inb=2 -> SUM=12 (00001100), c_out=0.
- Carry-in only: ina=0, inb=0, c_in=1 -> SUM=1, c_out=0. Then ina=15, inb=15, c_in=0 -> SUM=30 (00011110), c_out=0.
- Overflow and full ripple:
  - ina=255, inb=0, c_in=1 -> SUM=0, c_out=1.
  - ina=255, inb=255, c_in=1 -> SUM=255, c_out=1.
  - ina=128, inb=128, c_in=0 -> SUM=0, c_out=1.
- Latency and hold: change inputs between edges (e.g. 10+5 then 3+3 before the edge) -> only the value present at the edge (6) is registered. Outputs stay stable between edges.
- Reset mid-operation: while adding 100+100 (SUM=200), assert rst for one edge -> SUM=0, c_out=0. Deassert with inputs 1+1 -> SUM=2 after the next edge.
- Exhaustive/random check: all ina/inb pairs with c_in in {0,1}, compared against a reference (WIDTH+1)-bit add one cycle later.
